// File: rtl/mk_pkg.sv
// Shared definitions for the MK5303 control path: opcode constants, instruction
// field positions and the controller state encoding. The ALU imports the same
// opcode constants so both sides always agree on the opcode map.
package mk_pkg;

   // ALU opcodes
   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_INC  = 6'b010000;
   localparam logic [5:0] OP_DEC  = 6'b010001;
   localparam logic [5:0] OP_AND  = 6'b100000;
   localparam logic [5:0] OP_OR   = 6'b100001;
   localparam logic [5:0] OP_XOR  = 6'b100010;
   localparam logic [5:0] OP_NOT  = 6'b010010;
   localparam logic [5:0] OP_SHR  = 6'b001000;
   localparam logic [5:0] OP_SHL  = 6'b001001;
   localparam logic [5:0] OP_ROR  = 6'b001010;
   localparam logic [5:0] OP_ROL  = 6'b001011;

   // Control opcodes
   localparam logic [5:0] OP_NOP  = 6'b111110;
   localparam logic [5:0] OP_HALT = 6'b111111;

   // Instruction field positions; bit 0 is reserved and ignored
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 10;
   localparam int RD_MSB  = 9;
   localparam int RD_LSB  = 7;
   localparam int RS1_MSB = 6;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 1;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALTED    = 3'd5
   } state_t;

endpackage

// File: rtl/mk_op_legal.sv
// Opcode classifier: splits a 6-bit opcode into ALU / NOP / HALT / illegal.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the opcode input continuously.
module mk_op_legal
   import mk_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       is_alu,
   output logic       is_nop,
   output logic       is_halt,
   output logic       is_illegal
);

   // Exactly one of the four outputs is high for any opcode value
   always_comb begin
      is_alu  = 1'b0;
      is_nop  = 1'b0;
      is_halt = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_INC, OP_DEC,
         OP_AND, OP_OR,  OP_XOR, OP_NOT,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: is_alu  = 1'b1;
         OP_NOP:                         is_nop  = 1'b1;
         OP_HALT:                        is_halt = 1'b1;
         default:                        ;
      endcase
      is_illegal = ~(is_alu | is_nop | is_halt);
   end

endmodule

// File: rtl/mk_ctrl_decode.sv
// Fetch/decode/writeback sequencer driving the MK5303 ALU opcode and register-file addresses.
// Latency: ALU instruction 4 cycles, NOP/illegal 2 cycles, plus any fetch wait states.
// Backpressure: FETCH holds with imem_req high and pc stable until imem_valid; no other stalls.
module mk_ctrl_decode
   import mk_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [5:0]         alu_opcode,
   output logic [2:0]         rf_raddr1,
   output logic [2:0]         rf_raddr2,
   output logic               rf_we,
   output logic [2:0]         rf_waddr,
   output logic               busy,
   output logic               halted,
   output logic               illegal_op,
   output logic [PC_W-1:0]    pc
);

   state_t             state;
   logic [INSTR_W-1:0] ir;
   logic               op_alu;
   logic               op_nop;
   logic               op_halt;
   logic               op_illegal;
   logic               ir_rsvd_unused;

   // Reserved instruction bit carries no meaning
   assign ir_rsvd_unused = ir[0];

   mk_op_legal u_op_legal (
      .opcode     (ir[OPC_MSB:OPC_LSB]),
      .is_alu     (op_alu),
      .is_nop     (op_nop),
      .is_halt    (op_halt),
      .is_illegal (op_illegal)
   );

   assign imem_addr = pc;

   // Sequencer: state, pc, IR and the registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         pc       <= '0;
         ir       <= '0;
         imem_req <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  pc       <= '0;
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (imem_valid) begin
                  ir       <= imem_data;
                  state    <= ST_DECODE;
                  imem_req <= 1'b0;
               end
            end
            ST_DECODE: begin
               if (op_alu) begin
                  state <= ST_EXECUTE;
               end else if (op_halt) begin
                  // pc stays on the HALT instruction
                  state  <= ST_HALTED;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else if (op_nop || op_illegal) begin
                  pc       <= pc + PC_W'(1);
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end
            end
            ST_EXECUTE: begin
               state    <= ST_WRITEBACK;
               rf_we    <= 1'b1;
               rf_waddr <= ir[RD_MSB:RD_LSB];
            end
            ST_WRITEBACK: begin
               rf_we    <= 1'b0;
               pc       <= pc + PC_W'(1);
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Datapath-facing decode from state and IR; illegal opcodes present ADD (000000) to the ALU
   always_comb begin
      alu_opcode = '0;
      rf_raddr1  = '0;
      rf_raddr2  = '0;
      illegal_op = 1'b0;
      if (state == ST_DECODE || state == ST_EXECUTE || state == ST_WRITEBACK) begin
         alu_opcode = op_illegal ? 6'b000000 : ir[OPC_MSB:OPC_LSB];
         rf_raddr1  = ir[RS1_MSB:RS1_LSB];
         rf_raddr2  = ir[RS2_MSB:RS2_LSB];
      end
      if (state == ST_DECODE) begin
         illegal_op = op_illegal;
      end
   end

endmodule

// File: tb/tb_mk_ctrl_decode.sv
// Scoreboard bench for mk_ctrl_decode: an instruction-level model expands each
// program into expected fetch/write/illegal/halt events; a monitor pops and checks.
module tb_mk_ctrl_decode;

   localparam int PC_W = 8;

   localparam int EV_FETCH = 0;
   localparam int EV_ILL   = 1;
   localparam int EV_WR    = 2;
   localparam int EV_HALT  = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid = 1'b0;
   logic [15:0]     imem_data = '0;
   logic [5:0]      alu_opcode;
   logic [2:0]      rf_raddr1;
   logic [2:0]      rf_raddr2;
   logic            rf_we;
   logic [2:0]      rf_waddr;
   logic            busy;
   logic            halted;
   logic            illegal_op;
   logic [PC_W-1:0] pc;

   mk_ctrl_decode #(.PC_W(PC_W), .INSTR_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_data  (imem_data),
      .alu_opcode (alu_opcode),
      .rf_raddr1  (rf_raddr1),
      .rf_raddr2  (rf_raddr2),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .busy       (busy),
      .halted     (halted),
      .illegal_op (illegal_op),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   // kind, addr(pc), op, src1, src2, dest, cycle offset, fetch hold length
   typedef struct {
      int kind;
      int addr;
      int op;
      int a1;
      int a2;
      int wd;
      int dt;
      int hold;
   } ev_t;

   ev_t         exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] prog [0:1023];
   int          waits [0:1023];
   bit          mon_en = 1'b0;
   int          legal_ops [12] = '{0, 1, 16, 17, 32, 33, 34, 18, 8, 9, 10, 11};

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal_alu(input int op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: walk the program instruction by instruction (k-th fetch is at pc k mod 256)
   task automatic model_run(input int len);
      int gap = -1;
      for (int k = 0; k < len; k++) begin
         logic [15:0] ins;
         int op, pcv;
         bit alu, ill;
         ins = prog[k];
         op  = int'(ins[15:10]);
         pcv = k % 256;
         alu = is_legal_alu(op);
         ill = !alu && op != 62 && op != 63;
         exp_q.push_back('{EV_FETCH, pcv, ill ? 0 : op, int'(ins[6:4]), int'(ins[3:1]), 0, gap, waits[k] + 1});
         if (alu) begin
            exp_q.push_back('{EV_WR, pcv, op, int'(ins[6:4]), int'(ins[3:1]), int'(ins[9:7]), 2, 0});
            gap = 3;
         end else if (op == 63) begin
            exp_q.push_back('{EV_HALT, pcv, 0, 0, 0, 0, 1, 0});
            break;
         end else begin
            if (ill) exp_q.push_back('{EV_ILL, pcv, 0, 0, 0, 0, 0, 0});
            gap = 1;
         end
      end
   endtask

   task automatic pop_exp(input int kind, output ev_t e, output bit ok);
      e  = '{default: 0};
      ok = 1'b0;
      if (exp_q.size() == 0) begin
         chk("unexpected event kind", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("event kind", kind, e.kind);
         ok = (e.kind == kind);
      end
   endtask

   // Instruction memory: serves the k-th fetch of a run from prog[k] after waits[k] stall cycles
   initial begin : responder
      int fidx, wcnt;
      fidx = 0;
      wcnt = 0;
      forever begin
         @(negedge clk);
         if (!busy || !rst_n) begin
            fidx = 0;
            wcnt = 0;
         end
         if (imem_req) begin
            if (wcnt < waits[fidx]) begin
               imem_valid = 1'b0;
               imem_data  = 16'($urandom);
               wcnt++;
            end else begin
               imem_valid = 1'b1;
               imem_data  = prog[fidx];
               fidx++;
               wcnt = 0;
            end
         end else begin
            // noise outside FETCH must be ignored
            imem_valid = 1'($urandom);
            imem_data  = 16'($urandom);
         end
      end
   end

   // Monitor: turns DUT activity into events and checks them against the queue
   initial begin : monitor
      int   cyc, rise_cyc, fall_cyc, prev_addr;
      logic prev_req, prev_halt;
      ev_t  e;
      bit   ok;
      cyc = 0; rise_cyc = 0; fall_cyc = 0; prev_addr = 0;
      prev_req = 1'b0; prev_halt = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en && rst_n) begin
            if (imem_req && !prev_req) rise_cyc = cyc;
            if (imem_req && prev_req) chk("imem_addr stable in fetch", int'(imem_addr), prev_addr);
            if (!imem_req && prev_req) begin
               pop_exp(EV_FETCH, e, ok);
               if (ok) begin
                  chk("fetch addr", prev_addr, e.addr);
                  chk("decode alu_opcode", int'(alu_opcode), e.op);
                  chk("decode rf_raddr1", int'(rf_raddr1), e.a1);
                  chk("decode rf_raddr2", int'(rf_raddr2), e.a2);
                  chk("fetch req cycles", cyc - rise_cyc, e.hold);
                  if (e.dt >= 0) chk("instr cycles to next fetch", rise_cyc - fall_cyc, e.dt);
               end
               fall_cyc = cyc;
            end
            if (illegal_op) begin
               pop_exp(EV_ILL, e, ok);
               if (ok) begin
                  chk("illegal pc", int'(pc), e.addr);
                  chk("illegal timing", cyc - fall_cyc, e.dt);
               end
            end
            if (rf_we) begin
               pop_exp(EV_WR, e, ok);
               if (ok) begin
                  chk("wb alu_opcode", int'(alu_opcode), e.op);
                  chk("wb rf_raddr1", int'(rf_raddr1), e.a1);
                  chk("wb rf_raddr2", int'(rf_raddr2), e.a2);
                  chk("wb rf_waddr", int'(rf_waddr), e.wd);
                  chk("wb pc", int'(pc), e.addr);
                  chk("wb timing", cyc - fall_cyc, e.dt);
               end
               if (imem_req || halted || illegal_op) chk("rf_we outside writeback", 1, 0);
            end
            if (halted && !prev_halt) begin
               pop_exp(EV_HALT, e, ok);
               if (ok) begin
                  chk("halt pc", int'(pc), e.addr);
                  chk("halt busy", int'(busy), 0);
                  chk("halt timing", cyc - fall_cyc, e.dt);
               end
            end
         end
         prev_req  = imem_req;
         prev_halt = halted;
         prev_addr = int'(imem_addr);
      end
   end

   // Start a program from IDLE/HALTED and wait (bounded) for it to halt
   task automatic run_prog(input int len, input bit pulses, input int budget);
      bit done;
      done = 1'b0;
      model_run(len);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (halted) begin
            done = 1'b1;
            break;
         end
         start = pulses && ($urandom_range(0, 5) == 0);
      end
      start = 1'b0;
      if (!done) begin
         miscompares++;
         $display("FAIL halt timeout: halted=%0d, required 1 within %0d cycles", halted, budget);
      end
      @(negedge clk);
      chk("expected events left over", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin : stimulus
      int   len;
      int   r;
      logic [5:0] op;
      bit   seen;
      for (int i = 0; i < 1024; i++) begin
         prog[i]  = 16'hFC00;
         waits[i] = 0;
      end
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset halted", int'(halted), 0);
      chk("reset imem_req", int'(imem_req), 0);
      chk("reset imem_addr", int'(imem_addr), 0);
      chk("reset alu_opcode", int'(alu_opcode), 0);
      chk("reset rf_raddr1", int'(rf_raddr1), 0);
      chk("reset rf_raddr2", int'(rf_raddr2), 0);
      chk("reset rf_we", int'(rf_we), 0);
      chk("reset rf_waddr", int'(rf_waddr), 0);
      chk("reset illegal_op", int'(illegal_op), 0);
      chk("reset pc", int'(pc), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle without start", int'(imem_req), 0);
      mon_en = 1'b1;

      // zero-wait ADD rd=2 rs1=2 rs2=2
      prog[0] = 16'h0124; prog[1] = 16'hFC00;
      run_prog(2, 1'b0, 50);

      // SUB with three fetch wait states
      prog[0] = 16'h0400; waits[0] = 3; prog[1] = 16'hFC00;
      run_prog(2, 1'b0, 50);
      waits[0] = 0;

      // illegal opcode 000111, then NOP
      prog[0] = 16'h1C00; prog[1] = 16'hF800; prog[2] = 16'hFC00;
      run_prog(3, 1'b0, 50);

      // HALT at pc=5 with start pulses mid-run, then restart from HALTED
      for (int i = 0; i < 5; i++) prog[i] = 16'hF800;
      prog[5] = 16'hFC00;
      run_prog(6, 1'b1, 100);
      chk("halted pc", int'(pc), 5);
      chk("halted flag", int'(halted), 1);
      run_prog(6, 1'b0, 100);

      // pc wrap: 258 NOPs then HALT lands at pc 2
      for (int i = 0; i < 258; i++) prog[i] = 16'hF800;
      prog[258] = 16'hFC00;
      run_prog(259, 1'b0, 1200);
      chk("pc after wrap", int'(pc), 2);

      // randomized programs with random wait states
      for (int n = 0; n < 30; n++) begin
         len = $urandom_range(5, 40);
         for (int k = 0; k < len - 1; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6) op = 6'(legal_ops[$urandom_range(0, 11)]);
            else if (r < 7) op = 6'd62;
            else begin
               op = 6'($urandom);
               while (is_legal_alu(int'(op)) || op >= 6'd62) op = 6'($urandom);
            end
            prog[k]  = {op, 10'($urandom)};
            waits[k] = $urandom_range(0, 3);
         end
         prog[len-1]  = {6'd63, 10'($urandom)};
         waits[len-1] = $urandom_range(0, 3);
         run_prog(len, 1'b1, len * 8 + 20);
      end

      // asynchronous reset while in WRITEBACK
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) waits[i] = 0;
      prog[0] = 16'h0124; prog[1] = 16'hFC00;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (rf_we) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("reached writeback", int'(seen), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async reset rf_we", int'(rf_we), 0);
      chk("async reset imem_req", int'(imem_req), 0);
      chk("async reset pc", int'(pc), 0);
      chk("async reset busy", int'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rf_we || imem_req || busy || halted) seen = 1'b1;
      end
      chk("idle after reset release", int'(seen), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
